// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and
// data-memory wait handling, with a stall-cycle performance counter.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        id_valid,
  input  logic [3:0]  ex_reg_dst,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        perf_clr,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        ex_mem_stall,
  output logic        mem_wb_bubble,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mem_miss;
  logic ld_use;
  logic mem_hold;
  logic br_kill;
  logic lu_stall;
  logic fl_kill;

  assign mem_miss = mem_req & ~mem_ready;
  assign ld_use   = ex_is_load & id_valid &
                    ((ex_reg_dst == id_rs1) |
                     (ex_reg_dst == id_rs2));

  always_comb begin
    state_d  = state_q;
    mem_hold = 1'b0;
    br_kill  = 1'b0;
    lu_stall = 1'b0;
    fl_kill  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_miss) begin
          mem_hold = 1'b1;
          state_d  = MEMWAIT;
        end else if (ex_branch_taken) begin
          br_kill = 1'b1;
          state_d = FLUSH;
        end else if (ld_use) begin
          lu_stall = 1'b1;
          state_d  = LDUSE;
        end
      end
      LDUSE: begin
        if (mem_miss) begin
          mem_hold = 1'b1;
          state_d  = MEMWAIT;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        fl_kill = 1'b1;
        if (mem_miss) begin
          mem_hold = 1'b1;
          state_d  = MEMWAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        // EX is frozen here, so a taken branch waits for RUN
        if (!mem_ready) mem_hold = 1'b1;
        else state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign pc_stall      = ~rst & (mem_hold | lu_stall);
  assign if_id_stall   = ~rst & (mem_hold | lu_stall);
  assign if_id_flush   = ~rst & (br_kill | fl_kill);
  assign id_ex_stall   = ~rst & mem_hold;
  assign id_ex_bubble  = ~rst & (br_kill | lu_stall);
  assign ex_mem_stall  = ~rst & mem_hold;
  assign mem_wb_bubble = ~rst & mem_hold;

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q != MEMWAIT && state_d == MEMWAIT) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == MEMWAIT && !mem_ready &&
                 wait_cnt_q != 8'hFF) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if (state_q == MEMWAIT && wait_cnt_d == MaxWait)
      mem_timeout_d = 1'b1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr)
      stall_cnt_d = 16'd0;
    else if (pc_stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign state        = state_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table through a scoreboard queue,
// plus timeout, async-reset and counter-saturation sequences.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  id_rs1 = '0, id_rs2 = '0, ex_reg_dst = '0;
  logic        id_valid = 0, ex_is_load = 0, ex_branch_taken = 0;
  logic        mem_req = 0, mem_ready = 0, perf_clr = 0;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic        id_ex_bubble, ex_mem_stall, mem_wb_bubble;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [6:0]  ctl;

  int errs = 0;
  int checks = 0;

  hazard_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_valid(id_valid),
    .ex_reg_dst(ex_reg_dst), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .state(state),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_bubble, ex_mem_stall, mem_wb_bubble};

  localparam logic [6:0] C0  = 7'b0000000;
  localparam logic [6:0] LU  = 7'b1100100;
  localparam logic [6:0] BR  = 7'b0010100;
  localparam logic [6:0] FL  = 7'b0010000;
  localparam logic [6:0] MEM = 7'b1101011;
  localparam logic [6:0] FLM = 7'b1111011;

  typedef struct {
    logic [3:0]  rs1, rs2, dst;
    logic [5:0]  fl;
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
  } vec_t;

  typedef struct {
    int          row;
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
  } exp_t;

  vec_t tbl[28];
  exp_t sb[$];

  function automatic vec_t mk(input logic [3:0] rs1, rs2, dst,
                              input logic [5:0] fl,
                              input logic [6:0] c,
                              input logic [1:0] st,
                              input logic [15:0] sc);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.dst = dst;
    v.fl = fl; v.ctl = c; v.st = st; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("row%0d ctl", e.row), 32'(ctl), 32'(e.ctl));
      chk($sformatf("row%0d state", e.row), 32'(state), 32'(e.st));
      chk($sformatf("row%0d stall_cycles", e.row),
          32'(stall_cycles), 32'(e.sc));
    end
  end

  task automatic idle();
    {id_valid, ex_is_load, ex_branch_taken} = '0;
    {mem_req, mem_ready, perf_clr} = '0;
    id_rs1 = '0; id_rs2 = '0; ex_reg_dst = '0;
  endtask

  initial begin
    // flags: {id_valid, ex_is_load, br, mem_req, mem_ready, perf_clr}
    tbl[0]  = mk(0, 0, 0, 6'b000000, C0,  0, 0);
    tbl[1]  = mk(1, 5, 5, 6'b110000, LU,  0, 0);
    tbl[2]  = mk(1, 5, 5, 6'b110000, C0,  1, 1);
    tbl[3]  = mk(0, 0, 0, 6'b000000, C0,  0, 1);
    tbl[4]  = mk(3, 0, 3, 6'b010000, C0,  0, 1);
    tbl[5]  = mk(3, 0, 3, 6'b110000, LU,  0, 1);
    tbl[6]  = mk(0, 0, 0, 6'b000000, C0,  1, 2);
    tbl[7]  = mk(3, 5, 4, 6'b110000, C0,  0, 2);
    tbl[8]  = mk(0, 5, 5, 6'b111000, BR,  0, 2);
    tbl[9]  = mk(0, 0, 0, 6'b000000, FL,  3, 2);
    tbl[10] = mk(0, 0, 0, 6'b000000, C0,  0, 2);
    tbl[11] = mk(0, 0, 0, 6'b001100, MEM, 0, 2);
    tbl[12] = mk(0, 0, 0, 6'b001100, MEM, 2, 3);
    tbl[13] = mk(0, 0, 0, 6'b001100, MEM, 2, 4);
    tbl[14] = mk(0, 0, 0, 6'b000110, C0,  2, 5);
    tbl[15] = mk(0, 0, 0, 6'b000000, C0,  0, 5);
    tbl[16] = mk(0, 0, 0, 6'b001000, BR,  0, 5);
    tbl[17] = mk(0, 0, 0, 6'b000100, FLM, 3, 5);
    tbl[18] = mk(0, 0, 0, 6'b000110, C0,  2, 6);
    tbl[19] = mk(7, 0, 7, 6'b110000, LU,  0, 6);
    tbl[20] = mk(0, 0, 0, 6'b000100, MEM, 1, 7);
    tbl[21] = mk(0, 0, 0, 6'b000110, C0,  2, 8);
    tbl[22] = mk(0, 0, 0, 6'b000001, C0,  0, 8);
    tbl[23] = mk(0, 0, 0, 6'b000000, C0,  0, 0);
    tbl[24] = mk(0, 0, 0, 6'b000110, C0,  0, 0);
    tbl[25] = mk(0, 0, 0, 6'b000101, MEM, 0, 0);
    tbl[26] = mk(0, 0, 0, 6'b000110, C0,  2, 0);
    tbl[27] = mk(0, 0, 0, 6'b000000, C0,  0, 0);

    // reset with hazard-provoking inputs: outputs must stay quiet
    mem_req = 1; ex_branch_taken = 1; ex_is_load = 1; id_valid = 1;
    #1 rst = 1;
    #1;
    chk("reset ctl", 32'(ctl), 0);
    chk("reset state", 32'(state), 0);
    chk("reset timeout", 32'(mem_timeout), 0);
    chk("reset stall_cycles", 32'(stall_cycles), 0);
    repeat (2) @(negedge clk);
    idle();
    rst = 0;

    for (int i = 0; i < 28; i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      id_rs1 = tbl[i].rs1;
      id_rs2 = tbl[i].rs2;
      ex_reg_dst = tbl[i].dst;
      {id_valid, ex_is_load, ex_branch_taken,
       mem_req, mem_ready, perf_clr} = tbl[i].fl;
      e.row = i; e.ctl = tbl[i].ctl;
      e.st = tbl[i].st; e.sc = tbl[i].sc;
      sb.push_back(e);
    end
    for (int n = 0; n < 10 && sb.size() > 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk("scoreboard drained", 32'(sb.size()), 0);
    chk("no timeout yet", 32'(mem_timeout), 0);

    // timeout with MAX_WAIT=4
    @(posedge clk);
    #1 idle();
    mem_req = 1; mem_ready = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("timeout after 3 waits", 32'(mem_timeout), 0);
    chk("memwait state", 32'(state), 2);
    @(posedge clk);
    #1;
    chk("timeout after 4 waits", 32'(mem_timeout), 1);
    chk("memwait held", 32'(state), 2);
    mem_ready = 1;
    @(posedge clk);
    #1;
    chk("run after ready", 32'(state), 0);
    chk("timeout sticky", 32'(mem_timeout), 1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("timeout still sticky", 32'(mem_timeout), 1);

    // async reset between edges while in MEMWAIT
    mem_req = 1; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset memwait", 32'(state), 2);
    #2 rst = 1;
    #1;
    chk("midrst state", 32'(state), 0);
    chk("midrst ctl", 32'(ctl), 0);
    chk("midrst timeout", 32'(mem_timeout), 0);
    chk("midrst stall_cycles", 32'(stall_cycles), 0);
    idle();
    #2 rst = 0;
    @(posedge clk);
    #1;
    chk("post-reset run", 32'(state), 0);
    chk("post-reset count", 32'(stall_cycles), 0);

    // saturation and clear
    mem_req = 1; mem_ready = 0;
    repeat (65534) @(posedge clk);
    #1;
    chk("count 65534", 32'(stall_cycles), 32'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("count saturated", 32'(stall_cycles), 32'hFFFF);
    chk("stall during sat", 32'(pc_stall), 1);
    perf_clr = 1;
    @(posedge clk);
    #1;
    chk("clear beats inc", 32'(stall_cycles), 0);
    perf_clr = 0;
    @(posedge clk);
    #1;
    chk("count after clear", 32'(stall_cycles), 1);
    mem_ready = 1;
    @(posedge clk);
    #1 idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
